// File: rtl/nes_pad_reader_if.sv
// nes_pad_reader_if
//   Bundles the pad-connector pins and the parallel controller byte of
//   nes_pad_reader so the reader and its host share one port.
//   Signals:
//     enable          host -> reader  allow automatic polling
//     poll_now        host -> reader  one-cycle request for an immediate frame
//     pad_data        pad  -> reader  serial button data, active-low
//     pad_latch       reader -> pad   latch strobe
//     pad_clk         reader -> pad   shift clock, idles high
//     controller_data reader -> host  button byte, 1 = pressed
//     data_valid      reader -> host  one-cycle pulse on byte update
//     changed         reader -> host  one-cycle pulse when the byte differs
//     busy            reader -> host  frame in progress
interface nes_pad_reader_if;
  logic       enable;
  logic       poll_now;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] controller_data;
  logic       data_valid;
  logic       changed;
  logic       busy;

  modport master (
    output enable, poll_now, pad_data,
    input  pad_latch, pad_clk, controller_data, data_valid, changed, busy
  );

  modport slave (
    input  enable, poll_now, pad_data,
    output pad_latch, pad_clk, controller_data, data_valid, changed, busy
  );
endinterface

// File: rtl/nes_pad_reader.sv
// nes_pad_reader
//   Polls a serial NES-style controller (latch / clock / data) and presents
//   the eight buttons as an active-high byte with valid and changed pulses.
//   Parameters:
//     DIV        clk cycles per protocol tick (>= 4)
//     POLL_TICKS idle ticks between frames (>= 1)
//   Ports:
//     clk    system clock
//     reset  asynchronous active-high reset
//     pad    nes_pad_reader_if.slave (pad pins, controls and button byte)
module nes_pad_reader #(
  parameter int DIV        = 250,
  parameter int POLL_TICKS = 1000
) (
  input  logic              clk,
  input  logic              reset,
  nes_pad_reader_if.slave   pad
);

  localparam int DW = $clog2(DIV);
  localparam int PW = $clog2(POLL_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TICKS - 1);

  typedef enum logic [2:0] {IDLE, LATCH, SHIFT, CLKLO, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          lat_q, lat_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          latch_q, latch_d;
  logic          pclk_q, pclk_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          changed_q, changed_d;
  logic          busy_q, busy_d;
  logic          tick;

  always_comb begin
    tick    = (div_q == DIV_LAST);
    div_d   = tick ? '0 : div_q + 1'b1;
    sync1_d = pad.pad_data;
    sync2_d = sync1_q;

    state_d = state_q;
    poll_d  = poll_q;
    lat_d   = lat_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: begin
        lat_d = 1'b0;
        if (pad.poll_now) begin
          poll_d  = '0;
          state_d = LATCH;
        end else if (tick && pad.enable) begin
          if (poll_q == POLL_LAST) begin
            poll_d  = '0;
            state_d = LATCH;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
      end
      LATCH: begin
        // lat_q marks that the first of the two latch ticks has passed
        bit_d = 3'd0;
        if (tick) begin
          if (lat_q) begin
            lat_d   = 1'b0;
            state_d = SHIFT;
          end else begin
            lat_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          shift_d[bit_q] = ~sync2_q;
          state_d        = (bit_q == 3'd7) ? DONE : CLKLO;
        end
      end
      CLKLO: begin
        if (tick) begin
          bit_d   = bit_q + 3'd1;
          state_d = SHIFT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it;
    // shift_d already holds the eighth bit when DONE is entered.
    latch_d   = (state_d == LATCH);
    pclk_d    = (state_d != CLKLO);
    busy_d    = (state_d != IDLE);
    valid_d   = (state_d == DONE);
    data_d    = (state_d == DONE) ? shift_d : data_q;
    changed_d = (state_d == DONE) && (shift_d != data_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      poll_q    <= '0;
      lat_q     <= 1'b0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b1;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      poll_q    <= poll_d;
      lat_q     <= lat_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      latch_q   <= latch_d;
      pclk_q    <= pclk_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
    end
  end

  assign pad.pad_latch       = latch_q;
  assign pad.pad_clk         = pclk_q;
  assign pad.controller_data = data_q;
  assign pad.data_valid      = valid_q;
  assign pad.changed         = changed_q;
  assign pad.busy            = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader
//   Directed bench for nes_pad_reader (DIV=4, POLL_TICKS=8) with a
//   behavioural pad: reloads while pad_latch is high, shifts on pad_clk rise,
//   drives the current bit active-low.
module tb_nes_pad_reader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nes_pad_reader_if padif ();

  nes_pad_reader #(.DIV(4), .POLL_TICKS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .pad   (padif)
  );

  // pad model
  logic [7:0] pad_pattern;
  logic [7:0] pad_sr;
  always @(posedge padif.pad_latch or posedge padif.pad_clk) begin
    if (padif.pad_latch) pad_sr <= pad_pattern;
    else                 pad_sr <= {1'b0, pad_sr[7:1]};
  end
  assign padif.pad_data = ~pad_sr[0];

  // monitors
  int dv_cnt = 0, fall_cnt = 0, rise_cnt = 0, latch_hi = 0, lo_run = 0, bad_lo = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_changed = 1'b0;
  always @(negedge padif.pad_clk) fall_cnt <= fall_cnt + 1;
  always @(posedge padif.pad_latch) rise_cnt <= rise_cnt + 1;
  always @(posedge clk) begin
    if (padif.data_valid) begin
      dv_cnt       <= dv_cnt + 1;
      last_data    <= padif.controller_data;
      last_changed <= padif.changed;
    end
    if (padif.pad_latch) latch_hi <= latch_hi + 1;
    if (!padif.pad_clk) lo_run <= lo_run + 1;
    else if (lo_run != 0) begin
      if (lo_run != 4) bad_lo <= bad_lo + 1;
      lo_run <= 0;
    end
  end

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_dv(input int budget, output bit ok);
    int d0;
    d0 = dv_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (dv_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_latch(input int budget, output int n, output bit ok);
    n  = 0;
    ok = padif.pad_latch;
    while (!ok && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      ok = padif.pad_latch;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    bit ok;
    pad_pattern       = 8'hA5;
    padif.enable      = 1'b1;
    padif.poll_now    = 1'b0;
    reset             = 1'b1;
    step(3);
    chk_cnt++; if (padif.pad_latch !== 1'b0) $display("FAIL rst_latch got %b want 0", padif.pad_latch); else pass_cnt++;
    chk_cnt++; if (padif.pad_clk !== 1'b1) $display("FAIL rst_pclk got %b want 1", padif.pad_clk); else pass_cnt++;
    chk_cnt++; if (padif.controller_data !== 8'h00) $display("FAIL rst_data got %h want 00", padif.controller_data); else pass_cnt++;
    chk_cnt++; if (padif.data_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", padif.data_valid); else pass_cnt++;
    chk_cnt++; if (padif.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", padif.busy); else pass_cnt++;
    reset = 1'b0;
    wait_latch(200, n, ok);
    chk_cnt++; if (!ok || n != 32) $display("FAIL first_latch_delay got %0d clk want 32", n); else pass_cnt++;
  endtask

  task automatic test_single_frame();
    int f0, h0, b0, d0;
    bit ok;
    f0 = fall_cnt; h0 = latch_hi; b0 = bad_lo; d0 = dv_cnt;
    wait_dv(300, ok);
    chk_cnt++; if (!ok) $display("FAIL a5_timeout got no data_valid want 1"); else pass_cnt++;
    step(2);
    chk_cnt++; if (dv_cnt - d0 != 1) $display("FAIL a5_dv_count got %0d want 1", dv_cnt - d0); else pass_cnt++;
    chk_cnt++; if (last_data !== 8'hA5) $display("FAIL a5_data got %h want a5", last_data); else pass_cnt++;
    chk_cnt++; if (last_changed !== 1'b1) $display("FAIL a5_changed got %b want 1", last_changed); else pass_cnt++;
    chk_cnt++; if (padif.controller_data !== 8'hA5) $display("FAIL a5_hold got %h want a5", padif.controller_data); else pass_cnt++;
    chk_cnt++; if (padif.data_valid !== 1'b0) $display("FAIL a5_valid_low got %b want 0", padif.data_valid); else pass_cnt++;
    chk_cnt++; if (latch_hi - h0 != 8) $display("FAIL a5_latch_len got %0d want 8", latch_hi - h0); else pass_cnt++;
    chk_cnt++; if (fall_cnt - f0 != 7) $display("FAIL a5_pclk_falls got %0d want 7", fall_cnt - f0); else pass_cnt++;
    chk_cnt++; if (bad_lo - b0 != 0) $display("FAIL a5_low_phase got %0d bad want 0", bad_lo - b0); else pass_cnt++;
  endtask

  task automatic test_changed();
    bit ok;
    wait_dv(300, ok);
    chk_cnt++; if (!ok) $display("FAIL hold_timeout got no data_valid want 1"); else pass_cnt++;
    chk_cnt++; if (last_data !== 8'hA5) $display("FAIL hold_data got %h want a5", last_data); else pass_cnt++;
    chk_cnt++; if (last_changed !== 1'b0) $display("FAIL hold_changed got %b want 0", last_changed); else pass_cnt++;
    pad_pattern = 8'h3C;
    wait_dv(300, ok);
    chk_cnt++; if (!ok) $display("FAIL 3c_timeout got no data_valid want 1"); else pass_cnt++;
    chk_cnt++; if (last_data !== 8'h3C) $display("FAIL 3c_data got %h want 3c", last_data); else pass_cnt++;
    chk_cnt++; if (last_changed !== 1'b1) $display("FAIL 3c_changed got %b want 1", last_changed); else pass_cnt++;
  endtask

  task automatic test_enable_mid_frame();
    int n, f0, r0, k;
    bit ok;
    pad_pattern = 8'h81;
    wait_latch(300, n, ok);
    f0 = fall_cnt;
    k  = 0;
    // three low pulses done and pad_clk high again: SHIFT with bit index 3
    while (k < 300 && !((fall_cnt - f0) >= 3 && padif.pad_clk)) begin
      step(1);
      k++;
    end
    chk_cnt++; if (!ok || k >= 300) $display("FAIL en_reach_bit3 got timeout want shift bit 3"); else pass_cnt++;
    padif.enable = 1'b0;
    wait_dv(300, ok);
    chk_cnt++; if (!ok) $display("FAIL en_timeout got no data_valid want 1"); else pass_cnt++;
    chk_cnt++; if (last_data !== 8'h81) $display("FAIL en_data got %h want 81", last_data); else pass_cnt++;
    chk_cnt++; if (last_changed !== 1'b1) $display("FAIL en_changed got %b want 1", last_changed); else pass_cnt++;
    r0 = rise_cnt;
    step(100);
    chk_cnt++; if (rise_cnt != r0) $display("FAIL en_no_poll got %0d latches want 0", rise_cnt - r0); else pass_cnt++;
    chk_cnt++; if (padif.busy !== 1'b0) $display("FAIL en_idle_busy got %b want 0", padif.busy); else pass_cnt++;
    padif.enable = 1'b1;
  endtask

  task automatic test_reset_mid_clklo();
    int n, k, d0;
    bit ok;
    k = 0;
    while (k < 300 && padif.pad_clk) begin
      step(1);
      k++;
    end
    chk_cnt++; if (k >= 300) $display("FAIL rc_reach_clklo got timeout want pad_clk low"); else pass_cnt++;
    step(1);
    d0 = dv_cnt;
    reset = 1'b1;
    #1;
    chk_cnt++; if (padif.pad_clk !== 1'b1) $display("FAIL rc_pclk got %b want 1", padif.pad_clk); else pass_cnt++;
    chk_cnt++; if (padif.busy !== 1'b0) $display("FAIL rc_busy got %b want 0", padif.busy); else pass_cnt++;
    chk_cnt++; if (padif.controller_data !== 8'h00) $display("FAIL rc_data got %h want 00", padif.controller_data); else pass_cnt++;
    step(3);
    reset = 1'b0;
    wait_latch(200, n, ok);
    chk_cnt++; if (!ok || n != 32) $display("FAIL rc_relatch got %0d clk want 32", n); else pass_cnt++;
    chk_cnt++; if (padif.controller_data !== 8'h00) $display("FAIL rc_data_pre got %h want 00", padif.controller_data); else pass_cnt++;
    chk_cnt++; if (dv_cnt != d0) $display("FAIL rc_no_dv got %0d pulses want 0", dv_cnt - d0); else pass_cnt++;
    wait_dv(300, ok);
    chk_cnt++; if (!ok || last_data !== 8'h81) $display("FAIL rc_resume_data got %h want 81", last_data); else pass_cnt++;
    chk_cnt++; if (last_changed !== 1'b1) $display("FAIL rc_resume_changed got %b want 1", last_changed); else pass_cnt++;
  endtask

  task automatic test_poll_now();
    int d0, r0, k, f0;
    bit ok;
    padif.enable = 1'b0;
    pad_pattern  = 8'hC3;
    step(5);
    d0 = dv_cnt; r0 = rise_cnt;
    padif.poll_now = 1'b1;
    step(1);
    padif.poll_now = 1'b0;
    chk_cnt++; if (padif.pad_latch !== 1'b1) $display("FAIL pn_latch got %b want 1", padif.pad_latch); else pass_cnt++;
    chk_cnt++; if (padif.busy !== 1'b1) $display("FAIL pn_busy got %b want 1", padif.busy); else pass_cnt++;
    f0 = fall_cnt;
    k  = 0;
    while (k < 300 && !((fall_cnt - f0) >= 1 && padif.pad_clk)) begin
      step(1);
      k++;
    end
    padif.poll_now = 1'b1;
    step(1);
    padif.poll_now = 1'b0;
    wait_dv(300, ok);
    chk_cnt++; if (!ok || last_data !== 8'hC3) $display("FAIL pn_data got %h want c3", last_data); else pass_cnt++;
    chk_cnt++; if (last_changed !== 1'b1) $display("FAIL pn_changed got %b want 1", last_changed); else pass_cnt++;
    step(100);
    chk_cnt++; if (dv_cnt - d0 != 1) $display("FAIL pn_one_dv got %0d want 1", dv_cnt - d0); else pass_cnt++;
    chk_cnt++; if (rise_cnt - r0 != 1) $display("FAIL pn_one_frame got %0d want 1", rise_cnt - r0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_changed();
    test_enable_mid_frame();
    test_reset_mid_clklo();
    test_poll_now();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
